cipher_shift_pipe_n: RTL

Parametrised multi-lane Caesar shift stage with valid/ready flow control. Encrypts or decrypts LANES ASCII bytes per beat. Each uppercase, lowercase or digit byte is rotated within its own alphabet by a key that can step per message. It sits in the cipher datapath beside the existing encrypt/decrypt shift stages, and replaces the fixed single-byte, no-backpressure variant for wide streams.

---
 rtl/cipher_shift_pipe_n.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/cipher_shift_pipe_n.sv
// cipher_shift_pipe_n: multi-lane Caesar shift stage with a two-deep valid/ready pipeline.
// Upper, lower and (optionally) digit bytes rotate within their own alphabet by
// k = shift_amt + rot_cnt. rot_cnt steps every rot_freq accepted beats and restarts on msg_start.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake (in_ready is combinational from pipeline state)
//   in_data/in_keep     LANES bytes, lane i = in_data[8i+7:8i], per-lane keep
//   mode                0 encrypt, 1 decrypt (sampled per beat)
//   shift_amt           base key (sampled per beat)
//   rot_freq            key-step period in beats, 0 = no rotation (sampled per beat)
//   msg_start           first beat of a message; restarts the key rotation
//   out_valid/out_ready output handshake
//   out_data/out_keep   transformed bytes and delayed keep, registered
module cipher_shift_pipe_n #(
    parameter int unsigned LANES    = 4,
    parameter int unsigned SHIFT_W  = 5,
    parameter bit          DIGIT_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    input  logic [LANES-1:0]     in_keep,
    input  logic                 mode,
    input  logic [SHIFT_W-1:0]   shift_amt,
    input  logic [2:0]           rot_freq,
    input  logic                 msg_start,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic [LANES-1:0]     out_keep
);

    // Key width: holds 2^SHIFT_W-1 + 25 without truncation.
    localparam int unsigned KW = ((SHIFT_W > 5) ? SHIFT_W : 5) + 1;

    localparam logic [1:0] CLS_PASS  = 2'd0;
    localparam logic [1:0] CLS_UPPER = 2'd1;
    localparam logic [1:0] CLS_LOWER = 2'd2;
    localparam logic [1:0] CLS_DIGIT = 2'd3;

    // Pipeline state
    logic                 rdy_en;
    logic                 s1_v;
    logic [2*LANES-1:0]   s1_cls;
    logic [5*LANES-1:0]   s1_idx;
    logic [8*LANES-1:0]   s1_byte;
    logic [LANES-1:0]     s1_keep;
    logic                 s1_mode;
    logic [KW-1:0]        s1_key;
    logic [4:0]           rot_cnt;
    logic [2:0]           beat_cnt;

    // Combinational helpers
    logic                 s2_adv;
    logic                 s1_adv;
    logic                 accept;
    logic [2*LANES-1:0]   cls_c;
    logic [5*LANES-1:0]   idx_c;
    logic [4:0]           rot_base;
    logic [2:0]           beat_base;
    logic [4:0]           rot_nxt;
    logic [2:0]           beat_nxt;
    logic [KW-1:0]        key_c;
    logic [4:0]           km26;
    logic [4:0]           km10;
    logic [1:0]           cls;
    logic [5:0]           modv;
    logic [5:0]           kmv;
    logic [5:0]           sum;
    logic [7:0]           basev;
    logic [8*LANES-1:0]   s2_data_c;

    // Handshake: S2 drains when empty or accepted downstream, S1 follows.
    // rdy_en keeps in_ready low until the first edge after reset release.
    always_comb begin
        s2_adv   = !out_valid || out_ready;
        s1_adv   = s1_v && s2_adv;
        in_ready = rdy_en && (!s1_v || s1_adv);
        accept   = in_valid && in_ready;
    end

    // Lane classification into alphabet class and index.
    always_comb begin
        cls_c = '0;
        idx_c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (in_data[8*i +: 8] >= 8'h41 && in_data[8*i +: 8] <= 8'h5A) begin
                cls_c[2*i +: 2] = CLS_UPPER;
                idx_c[5*i +: 5] = 5'(in_data[8*i +: 8] - 8'h41);
            end else if (in_data[8*i +: 8] >= 8'h61 && in_data[8*i +: 8] <= 8'h7A) begin
                cls_c[2*i +: 2] = CLS_LOWER;
                idx_c[5*i +: 5] = 5'(in_data[8*i +: 8] - 8'h61);
            end else if (DIGIT_EN && in_data[8*i +: 8] >= 8'h30 && in_data[8*i +: 8] <= 8'h39) begin
                cls_c[2*i +: 2] = CLS_DIGIT;
                idx_c[5*i +: 5] = 5'(in_data[8*i +: 8] - 8'h30);
            end
        end
    end

    // Effective key and rotation step; msg_start reloads counters before stepping.
    always_comb begin
        rot_base  = msg_start ? 5'd0 : rot_cnt;
        beat_base = msg_start ? 3'd0 : beat_cnt;
        key_c     = KW'(shift_amt) + KW'(rot_base);
        rot_nxt   = rot_base;
        beat_nxt  = beat_base;
        if (rot_freq == 3'd0) begin
            rot_nxt  = 5'd0;
            beat_nxt = 3'd0;
        end else if (4'(beat_base) + 4'd1 >= 4'(rot_freq)) begin
            beat_nxt = 3'd0;
            rot_nxt  = (rot_base == 5'd25) ? 5'd0 : rot_base + 5'd1;
        end else begin
            beat_nxt = beat_base + 3'd1;
        end
    end

    // Rotation of S1 lanes; sum < 2*modulus so one conditional subtract suffices.
    always_comb begin
        s2_data_c = '0;
        km26      = 5'(s1_key % KW'(26));
        km10      = 5'(s1_key % KW'(10));
        cls       = CLS_PASS;
        modv      = 6'd26;
        kmv       = 6'd0;
        sum       = 6'd0;
        basev     = 8'h41;
        for (int unsigned i = 0; i < LANES; i++) begin
            cls   = s1_cls[2*i +: 2];
            modv  = 6'd26;
            kmv   = 6'(km26);
            basev = 8'h41;
            if (cls == CLS_LOWER) begin
                basev = 8'h61;
            end else if (cls == CLS_DIGIT) begin
                modv  = 6'd10;
                kmv   = 6'(km10);
                basev = 8'h30;
            end
            if (s1_mode) begin
                sum = 6'(s1_idx[5*i +: 5]) + modv - kmv;
            end else begin
                sum = 6'(s1_idx[5*i +: 5]) + kmv;
            end
            if (sum >= modv) begin
                sum = sum - modv;
            end
            if (s1_keep[i]) begin
                s2_data_c[8*i +: 8] = (cls == CLS_PASS) ? s1_byte[8*i +: 8] : basev + 8'(sum);
            end
        end
    end

    // Stage registers and key-rotation counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_en    <= 1'b0;
            s1_v      <= 1'b0;
            s1_cls    <= '0;
            s1_idx    <= '0;
            s1_byte   <= '0;
            s1_keep   <= '0;
            s1_mode   <= 1'b0;
            s1_key    <= '0;
            rot_cnt   <= 5'd0;
            beat_cnt  <= 3'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (accept) begin
                s1_v     <= 1'b1;
                s1_cls   <= cls_c;
                s1_idx   <= idx_c;
                s1_byte  <= in_data;
                s1_keep  <= in_keep;
                s1_mode  <= mode;
                s1_key   <= key_c;
                rot_cnt  <= rot_nxt;
                beat_cnt <= beat_nxt;
            end else if (s1_adv) begin
                s1_v <= 1'b0;
            end
            if (s2_adv) begin
                out_valid <= s1_v;
                if (s1_v) begin
                    out_data <= s2_data_c;
                    out_keep <= s1_keep;
                end
            end
        end
    end

endmodule
